mips32_mem_dump: RTL

- Debug read-back engine for the MIPS32 pipeline's word-addressed memory.
- Once the processor has halted, it walks a programmed address range and streams each (address, word) pair out over a valid/ready interface.
- It is the read-out counterpart to program/data loading, so the bench or a host link can inspect results such as a stored product without hierarchical peeks.
- Sits beside the processor on a spare synchronous read port of the memory.

---
 rtl/mips32_mem_dump.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips32_mem_dump.sv
// mips32_mem_dump: debug read-back engine for the MIPS32 word-addressed memory.
// Once the processor has halted, it walks [base_addr, base_addr+count) (wrapping
// modulo 2^ADDR_W) on a spare synchronous read port and streams each
// (address, word) pair out over a valid/ready interface.
//
// Optional feature: define MEM_DUMP_CHECKSUM_EN to add the `checksum` output,
// the running modulo-2^DATA_W sum of all words accepted on the stream.
//
// Stream handshake: a word transfers on a rising clk1 edge where
// out_valid && out_ready. Once out_valid is high it stays high, and
// out_addr/out_data stay stable, until that transfer happens (or an abort
// flushes the buffer). out_valid never depends on out_ready.
//
// state_dbg exposes the FSM encoding (IDLE=0, READ=1, DRAIN=2, FIN=3).
module mips32_mem_dump #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              halted,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
`ifdef MEM_DUMP_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Read walker
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  remaining;

    // One read can be in flight: data returns exactly one cycle after issue
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;

    // Two-entry output buffer holding (address, word) pairs
    logic [ADDR_W-1:0] fifo_addr [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic       accept_start;
    logic       active;
    logic       kill;
    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] load;

    assign accept_start = (state == IDLE) && start && halted;
    assign active       = (state == READ) || (state == DRAIN);
    assign kill         = active && abort;
    assign pop          = out_valid && out_ready;
    assign push         = pend && !kill;

    // Buffer slots that will be committed after this edge: entries held,
    // plus the word returning now, minus the word leaving now. Counting the
    // pop lets a new read go out every cycle while the consumer keeps up,
    // yet occupancy plus in-flight never exceeds the two slots.
    assign load  = occ + {1'b0, pend} - {1'b0, pop};
    assign issue = (state == READ) && !abort && (remaining != '0) && (load < 2'd2);

    assign mem_rd_en = issue;
    assign mem_addr  = issue ? rd_addr : '0;

    assign out_valid = (occ != 2'd0);
    assign out_addr  = fifo_addr[rd_ptr];
    assign out_data  = fifo_data[rd_ptr];

    assign busy      = active;
    assign done      = (state == FIN);
    assign state_dbg = state;

    // FSM state register
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_start) begin
                    state_nx = (count == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_nx = FIN;
                end else if (issue && (remaining == CNT_W'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = FIN;
                end else if (!pend && (occ == 2'd0)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address walker and remaining-word counter
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if (accept_start) begin
            rd_addr   <= base_addr;
            remaining <= count;
        end else if (issue) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Track the read in flight so its returning word can be tagged
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_addr <= rd_addr;
            end
        end
    end

    // Output buffer storage: capture returning words with their address
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else if (push) begin
            fifo_addr[wr_ptr] <= pend_addr;
            fifo_data[wr_ptr] <= mem_rdata;
        end
    end

    // Output buffer pointers and occupancy; abort flushes everything
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (kill) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Cancellation flag, held until the next accepted start
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else if (accept_start) begin
            aborted <= 1'b0;
        end else if (kill) begin
            aborted <= 1'b1;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    // Running sum of every word accepted on the stream
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept_start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule
